// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for an asynchronous single-bit input
// Ports: clk, reset (async active-low), d_i (async input), q_o (synchronized output)
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) s_q <= {2{RST_VAL}};
    else        s_q <= {s_q[0], d_i};
  assign q_o = s_q[1];
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampling UART receiver with one-entry holding register
// Ports: clk, reset (async active-low), parity_en, rx_uart (serial in),
//   rx_data_valid/rx_data_ready/rx_data (byte out), rx_parity_err, rx_frame_err,
//   rx_overrun (dropped-frame pulse), busy (FSM not idle)
module uart_rx_deframer import uart_pkg::*; #(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 parity_en,
  input  logic                 rx_uart,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q;
  logic                 pen_q, pen_d, perr_q, perr_d;
  logic                 valid_q, dperr_q, dferr_q, ovr_q;
  logic                 rx_s, last, done, ferr_new, load;
  uart_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d_i(rx_uart), .q_o(rx_s));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      pen_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      pen_q   <= pen_d;
      perr_q  <= perr_d;
    end
  assign last = (cnt_q == CW'(OVERSAMPLE - 1));
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    sh_d     = sh_q;
    pen_d    = pen_q;
    perr_d   = perr_q;
    done     = 1'b0;
    ferr_new = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == CW'(OVERSAMPLE / 2 - 1)) begin
        cnt_d   = '0;
        idx_d   = '0;
        pen_d   = parity_en;
        perr_d  = 1'b0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (last) begin
        cnt_d = '0;
        sh_d  = DATA_BITS'({rx_s, sh_q} >> 1);
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(DATA_BITS - 1)) state_d = pen_q ? PARITY : STOP;
      end
      PARITY: if (last) begin
        cnt_d   = '0;
        perr_d  = rx_s ^ (^sh_q);
        state_d = STOP;
      end
      STOP: if (last) begin
        cnt_d    = '0;
        done     = 1'b1;
        ferr_new = !rx_s;
        state_d  = rx_s ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = (state_q != IDLE);
  end
  // a pop and a push in the same cycle let the new frame replace the old one
  assign load = done && (!valid_q || rx_data_ready);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dperr_q <= 1'b0;
      dferr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= done && !load;
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= sh_q;
        dperr_q <= perr_q;
        dferr_q <= ferr_new;
      end else if (valid_q && rx_data_ready) valid_q <= 1'b0;
    end
  assign rx_data_valid = valid_q;
  assign rx_data       = data_q;
  assign rx_parity_err = dperr_q;
  assign rx_frame_err  = dferr_q;
  assign rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed scoreboard bench for uart_rx_deframer
module tb_uart_rx_deframer;
  typedef struct {logic [7:0] d; logic pe; logic fe;} exp_t;
  logic clk = 1'b0, reset = 1'b0, parity_en = 1'b0, rx_uart = 1'b1, rx_data_ready = 1'b1;
  logic rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun, busy;
  logic [7:0] rx_data;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, cyc = 0, t0 = 0, rise_cyc = -1, ovr_cnt = 0, ovr0 = 0, n_out = 0;
  logic prev_v = 1'b0, busy_seen = 1'b0;
  uart_rx_deframer dut (
    .clk(clk), .reset(reset), .parity_en(parity_en), .rx_uart(rx_uart),
    .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rx_overrun) ovr_cnt++;
    if (busy) busy_seen = 1'b1;
    if (rx_data_valid && !prev_v) rise_cyc = cyc;
    prev_v = rx_data_valid;
    if (rx_data_valid && rx_data_ready) begin
      n_out++;
      n_cmp++;
      assert (q.size() > 0) else begin n_bad++; $error("FAIL unexpected_out: got %h, expected none", rx_data); end
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        assert (rx_data === e.d) else begin n_bad++; $error("FAIL data: got %h, expected %h", rx_data, e.d); end
        n_cmp++;
        assert (rx_parity_err === e.pe) else begin n_bad++; $error("FAIL perr(%h): got %b, expected %b", e.d, rx_parity_err, e.pe); end
        n_cmp++;
        assert (rx_frame_err === e.fe) else begin n_bad++; $error("FAIL ferr(%h): got %b, expected %b", e.d, rx_frame_err, e.fe); end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin n_bad++; $error("FAIL %s: got %0d, expected %0d", tag, got, exp); end
  endtask
  task automatic send(input logic [7:0] d, input logic pb_en, input logic pb, input logic stop);
    t0 = cyc + 1;
    rx_uart = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx_uart = d[i];
      tick(16);
    end
    if (pb_en) begin
      rx_uart = pb;
      tick(16);
    end
    rx_uart = stop;
    tick(16);
  endtask
  initial begin
    tick(3);
    chk("rst_valid", rx_data_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_perr", rx_parity_err, 0);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_ovr", rx_overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick(4);
    q.push_back('{8'hA5, 1'b0, 1'b0});
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    chk("lat_nopar", rise_cyc - t0, 154);
    tick(4);
    chk("valid_drop", rx_data_valid, 0);
    parity_en = 1'b1;
    q.push_back('{8'h3C, 1'b0, 1'b0});
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    chk("lat_par", rise_cyc - t0, 170);
    q.push_back('{8'h3C, 1'b1, 1'b0});
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    parity_en = 1'b0;
    tick(8);
    busy_seen = 1'b0;
    ovr0 = n_out;
    rx_uart = 1'b0;
    tick(4);
    rx_uart = 1'b1;
    tick(30);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_idle", busy, 0);
    chk("glitch_no_out", n_out - ovr0, 0);
    q.push_back('{8'h55, 1'b0, 1'b1});
    send(8'h55, 1'b0, 1'b0, 1'b0);
    tick(64);
    chk("break_busy", busy, 1);
    rx_uart = 1'b1;
    tick(8);
    chk("break_idle", busy, 0);
    q.push_back('{8'h12, 1'b0, 1'b0});
    send(8'h12, 1'b0, 1'b0, 1'b1);
    tick(8);
    rx_data_ready = 1'b0;
    ovr0 = ovr_cnt;
    q.push_back('{8'h11, 1'b0, 1'b0});
    send(8'h11, 1'b0, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b0, 1'b1);
    tick(4);
    chk("ovr_pulses", ovr_cnt - ovr0, 1);
    chk("hold_valid", rx_data_valid, 1);
    chk("hold_data", rx_data, 8'h11);
    rx_data_ready = 1'b1;
    tick(2);
    chk("pop_valid", rx_data_valid, 0);
    rx_uart = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rx_uart = i[0];
      tick(16);
    end
    rx_uart = 1'b1;
    tick(6);
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", rx_data_valid, 0);
    tick(3);
    reset = 1'b1;
    tick(10);
    q.push_back('{8'h7E, 1'b0, 1'b0});
    send(8'h7E, 1'b0, 1'b0, 1'b1);
    tick(20);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
